// File: rtl/mux_4t1_1.sv
// 4-to-1 single-bit mux with a registered output copy and
// select-change tracking (pulse plus saturating change counter).
module mux_4t1_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic [1:0] S,
    output logic       O0,
    output logic       O0_r,
    output logic       sel_chg,
    output logic [7:0] chg_cnt
);

    logic [3:0] i_vec;
    logic       o0_r_d, o0_r_q;
    logic [1:0] s_d, s_q;
    logic       sel_chg_d, sel_chg_q;
    logic [7:0] chg_cnt_d, chg_cnt_q;

    // Indexed select: an unknown S yields X in simulation.
    assign i_vec = {I3, I2, I1, I0};
    assign O0    = i_vec[S];

    always_comb begin
        o0_r_d    = O0;
        s_d       = S;
        sel_chg_d = (S != s_q);
        chg_cnt_d = chg_cnt_q;
        if (sel_chg_d && (chg_cnt_q != 8'hFF)) begin
            chg_cnt_d = chg_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o0_r_q    <= 1'b0;
            s_q       <= 2'b00;
            sel_chg_q <= 1'b0;
            chg_cnt_q <= 8'h00;
        end else begin
            o0_r_q    <= o0_r_d;
            s_q       <= s_d;
            sel_chg_q <= sel_chg_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign O0_r    = o0_r_q;
    assign sel_chg = sel_chg_q;
    assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_mux_4t1_1.sv
// Scoreboard bench for mux_4t1_1: driver pushes expected outputs,
// separate monitors pop and compare.
module tb_mux_4t1_1;

    logic       clk;
    logic       rst;
    logic       I0, I1, I2, I3;
    logic [1:0] S;
    logic       O0, O0_r, sel_chg;
    logic [7:0] chg_cnt;

    mux_4t1_1 dut (
        .clk     (clk),
        .rst     (rst),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .S       (S),
        .O0      (O0),
        .O0_r    (O0_r),
        .sel_chg (sel_chg),
        .chg_cnt (chg_cnt)
    );

    typedef struct {
        string       nm;
        logic [10:0] v;
    } item_t;

    item_t clk_q[$];
    item_t now_q[$];
    event  now_ev;

    int total = 0;
    int bad   = 0;

    // Reference state: last sampled select and number of changes seen
    int prev_s  = 0;
    int n_chg   = 0;
    int o0r_ref = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mux_ref(input logic [3:0] iv, input int s);
        return (iv >> s) & 1;
    endfunction

    function automatic logic [3:0] ivec();
        return {I3, I2, I1, I0};
    endfunction

    function automatic logic [10:0] pack(input int o0, input int o0r,
                                         input int sc, input int cnt);
        logic [10:0] r;
        r = {o0[0], o0r[0], sc[0], cnt[7:0]};
        return r;
    endfunction

    // Monitor for registered outputs, sampled just after each edge
    initial begin
        item_t it;
        logic [10:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (clk_q.size() > 0) begin
                it  = clk_q.pop_front();
                got = {O0, O0_r, sel_chg, chg_cnt};
                total++;
                if (got !== it.v) begin
                    bad++;
                    $display("FAIL %s got=%h exp=%h t=%0t",
                             it.nm, got, it.v, $time);
                end
            end
        end
    end

    // Monitor for asynchronous/combinational observations
    initial begin
        item_t it;
        logic [10:0] got;
        forever begin
            @(now_ev);
            #1;
            while (now_q.size() > 0) begin
                it  = now_q.pop_front();
                got = {O0, O0_r, sel_chg, chg_cnt};
                total++;
                if (got !== it.v) begin
                    bad++;
                    $display("FAIL %s got=%h exp=%h t=%0t",
                             it.nm, got, it.v, $time);
                end
            end
        end
    end

    task automatic set_in(input logic [3:0] iv, input logic [1:0] s);
        {I3, I2, I1, I0} = iv;
        S = s;
    endtask

    task automatic model_reset();
        prev_s  = 0;
        n_chg   = 0;
        o0r_ref = 0;
    endtask

    // Immediate check of current outputs against the reference
    task automatic now_check(input string nm);
        item_t it;
        it.nm = nm;
        it.v  = pack(mux_ref(ivec(), int'(S)), o0r_ref,
                     rst ? 0 : -1, n_chg);
        if (!rst) it.v[8] = sel_chg;
        now_q.push_back(it);
        -> now_ev;
        #2;
    endtask

    // Drive one clocked transaction and predict the post-edge state
    task automatic step(input string nm, input logic [3:0] iv,
                        input logic [1:0] s);
        item_t it;
        int    sc;
        @(negedge clk);
        rst = 1'b0;
        set_in(iv, s);
        sc      = (int'(s) != prev_s) ? 1 : 0;
        n_chg   = (sc && n_chg < 255) ? n_chg + 1 : n_chg;
        prev_s  = int'(s);
        o0r_ref = mux_ref(iv, int'(s));
        it.nm   = nm;
        it.v    = pack(o0r_ref, o0r_ref, sc, n_chg);
        clk_q.push_back(it);
    endtask

    initial begin
        logic [3:0] iv;
        logic [1:0] s;
        logic [1:0] seq [4];
        rst = 1'b1;
        set_in(4'b0110, 2'b00);
        model_reset();
        #20;
        now_check("reset_state");

        // Combinational select walk, held 50 ns each, during reset
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        foreach (seq[k]) begin
            S = seq[k];
            #48;
            now_check("comb_walk");
        end

        // Unselected inputs must not disturb O0
        for (int k = 0; k < 6; k++) begin
            {I3, I1, I0} = 3'($urandom);
            #3;
            now_check("comb_unsel");
        end
        I2 = 1'b0;
        now_check("comb_sel_lo");
        I2 = 1'b1;
        now_check("comb_sel_hi");

        // Directed clocked sequence: three changes expected
        step("first_edge", 4'b0110, 2'b00);
        step("seq_01", 4'b0110, 2'b01);
        step("seq_11", 4'b0110, 2'b11);
        step("seq_10", 4'b0110, 2'b10);

        for (int k = 0; k < 200; k++) begin
            iv = 4'($urandom);
            s  = 2'($urandom);
            step("random", iv, s);
        end

        for (int k = 0; k < 300; k++) begin
            iv = 4'($urandom);
            step("saturate", iv, (k % 2) ? 2'b01 : 2'b10);
        end

        // Fresh count up to 5, then an asynchronous mid-cycle reset
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        now_check("reset_from_sat");
        for (int k = 1; k <= 5; k++) begin
            step("to_five", 4'($urandom), 2'(k));
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        now_check("async_reset");
        for (int k = 0; k < 4; k++) begin
            set_in(4'($urandom), 2'($urandom));
            #3;
            now_check("comb_in_reset");
        end

        // First edge after release with nonzero select counts a change
        step("release_s10", 4'b0100, 2'b10);
        step("release_hold", 4'b0100, 2'b10);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (clk_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", clk_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
